// File: rtl/mult.sv
// mult: sequential shift-add multiplier, one result per BITS+2 cycles.
// Ports: clock, reset (sync, active-high), valid (start strobe), is_signed,
//        multiplicand/multiplier (operands), busy, ready (1-cycle pulse),
//        hi/low (upper/lower halves of the 2*BITS product, held until next result).
module mult #(
    parameter int BITS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid,
    input  logic            is_signed,
    input  logic [BITS-1:0] multiplicand,
    input  logic [BITS-1:0] multiplier,
    output logic            busy,
    output logic            ready,
    output logic [BITS-1:0] hi,
    output logic [BITS-1:0] low
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam int CW = $clog2(BITS) + 1;

    state_t            r_state;
    logic [BITS-1:0]   r_mcand;
    logic [BITS-1:0]   r_mlr;
    logic [2*BITS-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_neg;
    logic              r_ready;
    logic [BITS-1:0]   r_hi;
    logic [BITS-1:0]   r_low;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [BITS-1:0]   w_mag_a;
    logic [BITS-1:0]   w_mag_b;
    logic [BITS-1:0]   w_addend;
    logic [BITS:0]     w_sum;
    logic [2*BITS-1:0] w_prod;

    // Magnitudes; 0x80..0 negates to itself, which is correct read as unsigned.
    assign w_a_neg  = is_signed & multiplicand[BITS-1];
    assign w_b_neg  = is_signed & multiplier[BITS-1];
    assign w_mag_a  = w_a_neg ? (BITS'(0) - multiplicand) : multiplicand;
    assign w_mag_b  = w_b_neg ? (BITS'(0) - multiplier) : multiplier;

    // BITS+1 adder into the upper half; the carry is shifted back in below.
    assign w_addend = r_mlr[0] ? r_mcand : '0;
    assign w_sum    = {1'b0, r_acc[2*BITS-1:BITS]} + {1'b0, w_addend};

    assign w_prod   = r_neg ? ((2*BITS)'(0) - r_acc) : r_acc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_mlr   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_ready <= 1'b0;
            r_hi    <= '0;
            r_low   <= '0;
        end else begin
            r_ready <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_mcand <= w_mag_a;
                        r_mlr   <= w_mag_b;
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= {w_sum, r_acc[BITS-1:1]};
                    r_mlr <= r_mlr >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(BITS - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_hi    <= w_prod[2*BITS-1:BITS];
                    r_low   <= w_prod[BITS-1:0];
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign ready = r_ready;
    assign hi    = r_hi;
    assign low   = r_low;

endmodule
